// File: rtl/clock_pkg.sv
// Shared types and constants for the time-of-day controller.
// Holds the set-mode state enum, display field codes and counter widths.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } t_clk_state;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;

    localparam int unsigned lp_hour_w = 5;
    localparam int unsigned lp_time_w = 6;

endpackage

// File: rtl/clock_ctrl_if.sv
// Pulse inputs and time/status outputs of the time-of-day controller.
// The master side drives the pulses; the slave side is the controller.
interface clock_ctrl_if;
    import clock_pkg::*;

    logic                 i_tick;
    logic                 i_mode;
    logic                 i_inc;
    logic                 o_stop;
    logic [lp_hour_w-1:0] o_hour;
    logic [lp_time_w-1:0] o_min;
    logic [lp_time_w-1:0] o_sec;
    logic [1:0]           o_field;
    logic                 o_day;

    modport master (
        output i_tick, i_mode, i_inc,
        input  o_stop, o_hour, o_min, o_sec, o_field, o_day
    );

    modport slave (
        input  i_tick, i_mode, i_inc,
        output o_stop, o_hour, o_min, o_sec, o_field, o_day
    );

endinterface

// File: rtl/mod_counter.sv
// Modulo counter counting 0..p_max and wrapping to 0; clear beats increment.
// o_carry is combinational so the owner can chain it within the same edge.
module mod_counter #(
    parameter int unsigned p_max = 59,
    parameter int unsigned p_w   = 6
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_inc,
    input  logic           i_clr,
    output logic [p_w-1:0] o_value,
    output logic           o_carry
);

    localparam logic [p_w-1:0] lp_max = p_w'(p_max);

    logic [p_w-1:0] value_q, value_d;
    logic           at_max;

    assign at_max = (value_q == lp_max);

    always_comb begin
        value_d = value_q;
        if (i_clr) begin
            value_d = '0;
        end else if (i_inc) begin
            value_d = at_max ? '0 : value_q + p_w'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign o_value = value_q;
    assign o_carry = i_inc && at_max;

endmodule

// File: rtl/clock_ctrl.sv
// Time-of-day controller: hh:mm:ss counters advanced by the divider tick,
// plus a RUN -> SET_HOUR -> SET_MIN edit sequence that freezes the divider.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned p_hour_max = 23,
    parameter int unsigned p_min_max  = 59,
    parameter int unsigned p_sec_max  = 59
) (
    input logic          i_clk,
    input logic          i_rst,
    clock_ctrl_if.slave  bus
);

    t_clk_state state_q, state_d;
    logic       day_q, day_d;

    logic run_st, set_hour_st, set_min_st, edit;
    logic sec_inc, sec_clr, min_inc, hour_inc;
    logic sec_carry, min_carry, hour_carry;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (bus.i_mode) state_d = SET_HOUR;
            SET_HOUR: if (bus.i_mode) state_d = SET_MIN;
            SET_MIN:  if (bus.i_mode) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= RUN;
            day_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            day_q   <= day_d;
        end
    end

    assign run_st      = (state_q == RUN);
    assign set_hour_st = (state_q == SET_HOUR);
    assign set_min_st  = (state_q == SET_MIN);
    // A mode press in the same cycle swallows the increment.
    assign edit        = bus.i_inc && !bus.i_mode;

    // Carries ripple only in RUN; edits wrap a single field in isolation.
    assign sec_inc  = run_st && bus.i_tick;
    assign sec_clr  = set_min_st && bus.i_mode;
    assign min_inc  = (run_st && sec_carry) || (set_min_st && edit);
    assign hour_inc = (run_st && min_carry) || (set_hour_st && edit);
    assign day_d    = run_st && hour_carry;

    mod_counter #(
        .p_max (p_sec_max),
        .p_w   (lp_time_w)
    ) u_sec (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (sec_inc),
        .i_clr   (sec_clr),
        .o_value (bus.o_sec),
        .o_carry (sec_carry)
    );

    mod_counter #(
        .p_max (p_min_max),
        .p_w   (lp_time_w)
    ) u_min (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (min_inc),
        .i_clr   (1'b0),
        .o_value (bus.o_min),
        .o_carry (min_carry)
    );

    mod_counter #(
        .p_max (p_hour_max),
        .p_w   (lp_hour_w)
    ) u_hour (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (hour_inc),
        .i_clr   (1'b0),
        .o_value (bus.o_hour),
        .o_carry (hour_carry)
    );

    always_comb begin
        bus.o_field = FIELD_NONE;
        case (state_q)
            SET_HOUR: bus.o_field = FIELD_HOUR;
            SET_MIN:  bus.o_field = FIELD_MIN;
            default:  bus.o_field = FIELD_NONE;
        endcase
    end

    assign bus.o_stop = (state_q != RUN);
    assign bus.o_day  = day_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: directed vector table, corner-case sequences and
// random pulses checked against a seconds-of-day reference model.
module tb_clock_ctrl;

    localparam int HOURS = 24;
    localparam int MINS  = 60;
    localparam int SECS  = 60;
    localparam int DAY_S = HOURS * MINS * SECS;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    clock_ctrl_if bus ();

    clock_ctrl #(
        .p_hour_max (HOURS - 1),
        .p_min_max  (MINS - 1),
        .p_sec_max  (SECS - 1)
    ) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: time kept as h/m/s, mode as 0 run, 1 hour edit, 2 minute edit.
    int m_h, m_m, m_s, m_mode, m_day;

    typedef struct {
        logic tick;
        logic mode;
        logic inc;
        int   hour;
        int   min;
        int   sec;
        int   field;
        int   stop;
        int   day;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic t, input logic md, input logic i, input int h,
                                input int m, input int s, input int f, input int st,
                                input int d);
        vec_t v;
        v.tick = t; v.mode = md; v.inc = i;
        v.hour = h; v.min = m; v.sec = s; v.field = f; v.stop = st; v.day = d;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_day = 0;
    endtask

    task automatic model_step(input logic t, input logic md, input logic i);
        int tot;
        m_day = 0;
        case (m_mode)
            0: begin
                if (t) begin
                    tot = m_h * 3600 + m_m * 60 + m_s + 1;
                    if (tot == DAY_S) begin
                        tot   = 0;
                        m_day = 1;
                    end
                    m_h = tot / 3600;
                    m_m = (tot / 60) % 60;
                    m_s = tot % 60;
                end
                if (md) m_mode = 1;
            end
            1: begin
                if (md) m_mode = 2;
                else if (i) m_h = (m_h + 1) % HOURS;
            end
            default: begin
                if (md) begin
                    m_mode = 0;
                    m_s    = 0;
                end else if (i) begin
                    m_m = (m_m + 1) % MINS;
                end
            end
        endcase
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".hour"},  int'(bus.o_hour),  m_h);
        chk({tag, ".min"},   int'(bus.o_min),   m_m);
        chk({tag, ".sec"},   int'(bus.o_sec),   m_s);
        chk({tag, ".field"}, int'(bus.o_field), m_mode);
        chk({tag, ".stop"},  int'(bus.o_stop),  (m_mode != 0) ? 1 : 0);
        chk({tag, ".day"},   int'(bus.o_day),   m_day);
    endtask

    task automatic cycle(input logic t, input logic md, input logic i, input string tag);
        bus.i_tick = t; bus.i_mode = md; bus.i_inc = i;
        @(posedge clk);
        #1;
        bus.i_tick = 1'b0; bus.i_mode = 1'b0; bus.i_inc = 1'b0;
        model_step(t, md, i);
        check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        bus.i_tick = 1'b0; bus.i_mode = 1'b0; bus.i_inc = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_model(tag);
    endtask

    initial begin
        bus.i_tick = 1'b0; bus.i_mode = 1'b0; bus.i_inc = 1'b0;
        model_reset();

        // Expected values worked out by hand from 00:00:00 in RUN.
        vecs[0]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 2, 0, 0, 0);
        vecs[2]  = mk(0, 0, 1, 0, 0, 2, 0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 2, 1, 1, 0);
        vecs[4]  = mk(1, 0, 0, 0, 0, 2, 1, 1, 0);
        vecs[5]  = mk(0, 0, 1, 1, 0, 2, 1, 1, 0);
        vecs[6]  = mk(0, 1, 1, 1, 0, 2, 2, 1, 0);
        vecs[7]  = mk(0, 0, 1, 1, 1, 2, 2, 1, 0);
        vecs[8]  = mk(1, 0, 0, 1, 1, 2, 2, 1, 0);
        vecs[9]  = mk(0, 1, 0, 1, 1, 0, 0, 0, 0);
        vecs[10] = mk(1, 1, 0, 1, 1, 1, 1, 1, 0);
        vecs[11] = mk(0, 1, 0, 1, 1, 1, 2, 1, 0);
        vecs[12] = mk(0, 1, 0, 1, 1, 0, 0, 0, 0);

        do_reset("reset0");
        for (int k = 0; k < 13; k++) begin
            bus.i_tick = vecs[k].tick; bus.i_mode = vecs[k].mode; bus.i_inc = vecs[k].inc;
            @(posedge clk);
            #1;
            bus.i_tick = 1'b0; bus.i_mode = 1'b0; bus.i_inc = 1'b0;
            model_step(vecs[k].tick, vecs[k].mode, vecs[k].inc);
            chk($sformatf("vec%0d.hour", k),  int'(bus.o_hour),  vecs[k].hour);
            chk($sformatf("vec%0d.min", k),   int'(bus.o_min),   vecs[k].min);
            chk($sformatf("vec%0d.sec", k),   int'(bus.o_sec),   vecs[k].sec);
            chk($sformatf("vec%0d.field", k), int'(bus.o_field), vecs[k].field);
            chk($sformatf("vec%0d.stop", k),  int'(bus.o_stop),  vecs[k].stop);
            chk($sformatf("vec%0d.day", k),   int'(bus.o_day),   vecs[k].day);
        end

        // 60 ticks roll seconds into the minute.
        do_reset("reset1");
        for (int k = 0; k < 60; k++) cycle(1, 0, 0, "tick60");
        chk("tick60.sec_const", int'(bus.o_sec), 0);
        chk("tick60.min_const", int'(bus.o_min), 1);
        chk("tick60.hour_const", int'(bus.o_hour), 0);
        chk("tick60.stop_const", int'(bus.o_stop), 0);

        // Preload 23:59:58 then cross midnight.
        do_reset("reset2");
        cycle(0, 1, 0, "pre");
        for (int k = 0; k < 23; k++) cycle(0, 0, 1, "pre_h");
        cycle(0, 1, 0, "pre");
        for (int k = 0; k < 59; k++) cycle(0, 0, 1, "pre_m");
        cycle(0, 1, 0, "pre");
        for (int k = 0; k < 58; k++) cycle(1, 0, 0, "pre_s");
        chk("pre.sec_const", int'(bus.o_sec), 58);
        cycle(1, 0, 0, "wrap1");
        chk("wrap1.hms_const", {bus.o_hour, bus.o_min, bus.o_sec}, {5'd23, 6'd59, 6'd59});
        cycle(1, 0, 0, "wrap2");
        chk("wrap2.hms_const", {bus.o_hour, bus.o_min, bus.o_sec}, 0);
        chk("wrap2.day_const", int'(bus.o_day), 1);
        cycle(0, 0, 0, "wrap3");
        chk("wrap3.day_const", int'(bus.o_day), 0);

        // Edit wrap without carry, ticks ignored while setting.
        do_reset("reset3");
        cycle(0, 1, 0, "edit");
        for (int k = 0; k < 25; k++) cycle(0, 0, 1, "edit_h");
        chk("edit.hour_const", int'(bus.o_hour), 1);
        chk("edit.field_h_const", int'(bus.o_field), 1);
        cycle(0, 1, 0, "edit");
        chk("edit.field_m_const", int'(bus.o_field), 2);
        for (int k = 0; k < 60; k++) cycle(0, 0, 1, "edit_m");
        chk("edit.min_const", int'(bus.o_min), 0);
        chk("edit.hour2_const", int'(bus.o_hour), 1);
        for (int k = 0; k < 5; k++) cycle(1, 0, 0, "edit_tick");
        cycle(0, 1, 0, "edit_exit");
        chk("edit_exit.stop_const", int'(bus.o_stop), 0);

        // Tick and mode together at sec 10.
        do_reset("reset4");
        for (int k = 0; k < 10; k++) cycle(1, 0, 0, "tm");
        cycle(1, 1, 0, "tm_both");
        chk("tm_both.sec_const", int'(bus.o_sec), 11);
        chk("tm_both.field_const", int'(bus.o_field), 1);

        // Reset in the middle of an edit.
        cycle(0, 0, 1, "rs");
        cycle(0, 1, 0, "rs");
        cycle(0, 0, 1, "rs");
        do_reset("rs_reset");
        chk("rs.hms_const", {bus.o_hour, bus.o_min, bus.o_sec}, 0);
        chk("rs.stop_const", int'(bus.o_stop), 0);

        // Random pulses with occasional reset.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset("rnd_reset");
            end else begin
                cycle(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 7) == 0),
                      logic'($urandom_range(0, 2) == 0), "rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Time-of-day controller that consumes the one-cycle pulse from the clock divider, keeps hours/minutes/seconds counters, and sequences a user set mode. While the user adjusts fields it holds the divider frozen through `o_stop`, so the time base resumes cleanly on exit. The block sits between the divider and the display/button logic of the clock design.

## Interface
- `p_hour_max`, 23: last hour value before wrap to 0.
- `p_min_max`, 59: last minute value before wrap.
- `p_sec_max`, 59: last second value before wrap.
- `i_clk`  in  1  system clock; all logic on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_tick`  in  1  one-cycle pulse from the divider, one per second.
- `i_mode`  in  1  one-cycle pulse (debounced button) that advances the set-mode state.
- `i_inc`  in  1  one-cycle pulse (debounced button) that increments the selected field.
- `o_stop`  out  1  freeze request to the divider; high in either set state.
- `o_hour`  out  5  current hour, binary.
- `o_min`  out  6  current minute, binary.
- `o_sec`  out  6  current second, binary.
- `o_field`  out  2  selected field: 0 none, 1 hour, 2 minute (drives display blink).
- `o_day`  out  1  one-cycle pulse on wrap from p_hour_max:p_min_max:p_sec_max to 0:0:0.

## Operation
- State machine: RUN, SET_HOUR, SET_MIN.
  - RUN: `i_mode` goes to SET_HOUR.
  - SET_HOUR: `i_mode` goes to SET_MIN.
  - SET_MIN: `i_mode` goes to RUN; seconds cleared to 0 on this transition.
  - Illegal encoding goes to RUN.
- RUN, `i_tick`=1:
  - sec+1.
  - When sec==p_sec_max: sec←0, min+1.
  - When min also ==p_min_max: min←0, hour+1.
  - When hour also ==p_hour_max: hour←0 and `o_day` pulses.
- Set states:
  - `i_tick` is ignored.
  - `i_inc` increments only the selected field, wrapping max→0 with no carry into other fields.
- Simultaneous events:
  - RUN with `i_tick` and `i_mode` together: the tick is applied and the state advances in the same edge.
  - `i_mode` and `i_inc` together in a set state: the mode change wins and `i_inc` is dropped.
  - `i_inc` in RUN is ignored.
- `o_stop` = (state != RUN). `o_field` is decoded from the state register.
- Reset:
  - state RUN; hour, min and sec 0.
  - `o_stop` 0, `o_field` 0, `o_day` 0.
  - Reset mid-set-mode abandons edits and releases `o_stop`.

## Timing
- All counters and `o_day` are registered.
- `i_tick` at edge n: `o_sec`/`o_min`/`o_hour` show the new value after edge n. `o_day` is high for exactly the cycle after edge n.
- `i_mode` at edge n: new state, `o_stop` and `o_field` are valid after edge n (one-cycle latency).
- The divider stops counting one cycle after `i_mode`. A divider pulse in that cycle arrives while the state is SET_HOUR and is discarded.
- `i_inc` at edge n: the field value updates after edge n. Back-to-back `i_inc` pulses each increment once.
- No internal backpressure. Every input pulse is consumed or dropped in the cycle it is presented.

## Structure
- Shared package `clock_pkg` holds:
  - state enum `t_clk_state` (RUN, SET_HOUR, SET_MIN);
  - field code constants (FIELD_NONE/HOUR/MIN);
  - width constants `lp_hour_w`=5 and `lp_time_w`=6.
- One sub-module: `mod_counter`.
  - Parameterised modulo counter with inputs `i_inc` and `i_clr` and output `o_carry` (combinational, = inc && value==max).
  - Instantiated three times.
  - Carry chaining into the next counter is gated by state in `clock_ctrl`.

## Test plan
- Reset then 60 `i_tick` pulses in RUN → `o_sec` returns to 0, `o_min`=1, `o_hour`=0, `o_stop` stays 0.
- Preload to 23:59:58 via set mode, exit, then 2 ticks → 23:59:59, then 00:00:00 with `o_day` high for exactly one cycle.
- `i_mode`, then 25 `i_inc` → `o_field`=1, `o_stop`=1, `o_hour`=1 (wraps at 23). `i_mode` again → `o_field`=2. 60 `i_inc` → `o_min` unchanged and `o_hour` unchanged (no carry).
- In SET_MIN, pulse `i_tick` ×5 → no change. `i_mode` → state RUN, `o_sec`=0, `o_stop`=0 on the next cycle.
- Same-cycle cases:
  - `i_mode`+`i_inc` in SET_HOUR → SET_MIN, hour unchanged.
  - `i_tick`+`i_mode` in RUN at sec=10 → sec=11 and state SET_HOUR.
- Assert `i_rst` while in SET_MIN with edited fields → next cycle 00:00:00, RUN, `o_stop`=0, `o_field`=0.
